// File: rtl/dsp_terminal_count_counter.sv
`default_nettype none
// ============================================================================
// Module   : dsp_terminal_count_counter
// Brief    : 48-bit enable-gated up-counter that emits a one-cycle pulse at
//            its terminal count, optionally halting there until reset.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_terminal_count_counter #(
  parameter string       FIXED_TCOUNT       = "TRUE",
  parameter logic [47:0] FIXED_TCOUNT_VALUE = 48'd375000000,
  parameter string       HALT_AT_TCOUNT     = "TRUE"
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        count_i,
  input  logic [47:0] tcount_i,
  output logic [47:0] count_o,
  output logic        tcount_reached_o
);

  localparam bit c_halt = (HALT_AT_TCOUNT == "TRUE");

  logic [47:0] w_tc;
  logic        w_match;
  logic [47:0] r_cnt;
  logic        r_halted;
  logic        r_pulse;

  if (FIXED_TCOUNT == "TRUE") begin : g_fixed_tc
    logic w_unused_tcount;
    assign w_unused_tcount = ^tcount_i;
    assign w_tc            = FIXED_TCOUNT_VALUE;
  end else begin : g_port_tc
    assign w_tc = tcount_i;
  end

  // A zero terminal count must never match, even when the count wraps to all-ones.
  assign w_match = count_i && !r_halted && (w_tc != 48'd0) && (r_cnt == (w_tc - 48'd1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= 48'd0;
      r_halted <= 1'b0;
      r_pulse  <= 1'b0;
    end else if (w_match) begin
      r_pulse <= 1'b1;
      if (c_halt) begin
        r_cnt    <= w_tc;
        r_halted <= 1'b1;
      end else begin
        r_cnt <= 48'd0;
      end
    end else begin
      r_pulse <= 1'b0;
      if (count_i && !r_halted) begin
        r_cnt <= r_cnt + 48'd1;
      end
    end
  end

  assign count_o          = r_cnt;
  assign tcount_reached_o = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_dsp_terminal_count_counter.sv
`default_nettype none
// Bench for dsp_terminal_count_counter: three instances (fixed/halt, fixed/wrap,
// run-time/wrap) checked every cycle against a behavioural model plus literal pins.
module tb_dsp_terminal_count_counter;

  logic        clk = 1'b0;
  logic        rst[3];
  logic        cen[3];
  logic [47:0] tc_r;
  logic [47:0] cnt_o[3];
  logic        pls_o[3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dsp_terminal_count_counter #(
    .FIXED_TCOUNT("TRUE"), .FIXED_TCOUNT_VALUE(48'd10), .HALT_AT_TCOUNT("TRUE")
  ) dut_h (
    .clk_i(clk), .rst_i(rst[0]), .count_i(cen[0]), .tcount_i(48'd0),
    .count_o(cnt_o[0]), .tcount_reached_o(pls_o[0])
  );

  dsp_terminal_count_counter #(
    .FIXED_TCOUNT("TRUE"), .FIXED_TCOUNT_VALUE(48'd10), .HALT_AT_TCOUNT("FALSE")
  ) dut_w (
    .clk_i(clk), .rst_i(rst[1]), .count_i(cen[1]), .tcount_i(48'hFFFF_FFFF_FFFF),
    .count_o(cnt_o[1]), .tcount_reached_o(pls_o[1])
  );

  dsp_terminal_count_counter #(
    .FIXED_TCOUNT("FALSE"), .FIXED_TCOUNT_VALUE(48'd10), .HALT_AT_TCOUNT("FALSE")
  ) dut_r (
    .clk_i(clk), .rst_i(rst[2]), .count_i(cen[2]), .tcount_i(tc_r),
    .count_o(cnt_o[2]), .tcount_reached_o(pls_o[2])
  );

  // Behavioural model: counts enabled cycles; pulse when that count reaches TC.
  longint m_cnt[3];
  bit     m_halt[3];
  bit     m_pulse[3];
  bit     m_valid[3];

  task automatic model_step(input int i, input bit r, input bit en, input longint tc, input bit halt);
    longint nxt;
    if (r) begin
      m_cnt[i] = 0; m_halt[i] = 0; m_pulse[i] = 0; m_valid[i] = 1;
    end else if (en && !m_halt[i]) begin
      nxt = m_cnt[i] + 1;
      if (tc != 0 && nxt == tc) begin
        m_pulse[i] = 1;
        if (halt) begin m_cnt[i] = tc; m_halt[i] = 1; end
        else m_cnt[i] = 0;
      end else begin
        m_pulse[i] = 0;
        m_cnt[i] = nxt & 64'h0000_FFFF_FFFF_FFFF;
      end
    end else begin
      m_pulse[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst[0], cen[0], 10, 1);
    model_step(1, rst[1], cen[1], 10, 0);
    model_step(2, rst[2], cen[2], longint'(tc_r), 0);
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m_valid[i]) begin
        n_cmp++;
        if (longint'(cnt_o[i]) != m_cnt[i]) begin
          n_err++;
          $display("FAIL model_count[%0d] got %0d expected %0d", i, cnt_o[i], m_cnt[i]);
        end
        n_cmp++;
        if (pls_o[i] !== m_pulse[i]) begin
          n_err++;
          $display("FAIL model_pulse[%0d] got %0b expected %0b", i, pls_o[i], m_pulse[i]);
        end
      end
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin rst[i] = 1'b0; cen[i] = 1'b0; end
  endtask

  int npulse;
  int ppos;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; cen[i] = 1'b1; m_valid[i] = 0;
      m_cnt[i] = 0; m_halt[i] = 0; m_pulse[i] = 0;
    end
    tc_r = 48'd3;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      check("reset_count", longint'(cnt_o[i]), 0);
      check("reset_pulse", longint'(pls_o[i]), 0);
    end
    idle_all();

    // Fixed TC=10 with halt: single pulse on the 10th enabled edge, then stuck.
    cen[0] = 1'b1;
    npulse = 0; ppos = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (pls_o[0]) begin npulse++; ppos = k; end
    end
    check("halt_pulse_count", npulse, 1);
    check("halt_pulse_pos", ppos, 10);
    check("halt_final_count", longint'(cnt_o[0]), 10);

    // Reset mid-period at cnt=5, then again while halted.
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    check("halt_mid_count", longint'(cnt_o[0]), 5);
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    check("halt_restart_count", longint'(cnt_o[0]), 0);
    for (int k = 1; k <= 10; k++) step();
    check("halt_restart_pulse", longint'(pls_o[0]), 1);
    step(); step();
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    for (int k = 1; k <= 10; k++) step();
    check("halt_rearm_pulse", longint'(pls_o[0]), 1);
    check("halt_rearm_count", longint'(cnt_o[0]), 10);

    // Reset coincides with the match edge.
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    for (int k = 1; k <= 9; k++) step();
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    check("coincide_pulse", longint'(pls_o[0]), 0);
    check("coincide_count", longint'(cnt_o[0]), 0);
    cen[0] = 1'b0;

    // Fixed TC=10 wrapping: pulses at 10, 20, 30 with count back at 0.
    rst[1] = 1'b1; step(); rst[1] = 1'b0; cen[1] = 1'b1;
    npulse = 0;
    for (int k = 1; k <= 35; k++) begin
      step();
      if (pls_o[1]) begin
        npulse++;
        check("wrap_pulse_pos", k, npulse * 10);
      end
    end
    check("wrap_pulse_count", npulse, 3);
    check("wrap_final_count", longint'(cnt_o[1]), 5);

    // Alternating enable: 10th enabled edge is edge 19.
    rst[1] = 1'b1; step(); rst[1] = 1'b0;
    ppos = 0;
    for (int k = 1; k <= 24; k++) begin
      cen[1] = k[0];
      step();
      if (pls_o[1] && ppos == 0) ppos = k;
    end
    check("toggle_pulse_pos", ppos, 19);
    cen[1] = 1'b0;

    // Run-time TC=3, then TC=0 never pulses.
    tc_r = 48'd3;
    rst[2] = 1'b1; step(); rst[2] = 1'b0; cen[2] = 1'b1;
    ppos = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (pls_o[2] && ppos == 0) ppos = k;
    end
    check("rt_pulse_pos", ppos, 3);
    tc_r = 48'd0;
    rst[2] = 1'b1; step(); rst[2] = 1'b0;
    npulse = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (pls_o[2]) npulse++;
    end
    check("rt_zero_pulses", npulse, 0);
    check("rt_zero_count", longint'(cnt_o[2]), 100);

    // Randomized traffic, model-checked every cycle.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) begin
        rst[i] = ($urandom_range(0, 39) == 0);
        cen[i] = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 15) == 0) tc_r = 48'($urandom_range(0, 6));
      step();
    end

    idle_all();
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
